// File: rtl/pdp8_ptr_pkg.sv
// Shared PDP-8 definitions for the I/O device slice.
// Holds the CPU major-state encodings, the IOT instruction field positions,
// the device select codes and the reader's own FSM state type.
// Ports: none (package).
package pdp8_ptr_pkg;

   // CPU major states as presented on the 'state' bus of pdp8_io devices
   localparam logic [3:0] ST_FETCH = 4'd0;
   localparam logic [3:0] ST_DEFER = 4'd1;
   localparam logic [3:0] ST_EXEC  = 4'd2;
   localparam logic [3:0] ST_IOT   = 4'd3;

   // IOT instruction fields within mb
   localparam int IOT_FN_LSB  = 0;
   localparam int IOT_FN_MSB  = 2;
   localparam int IOT_DEV_LSB = 3;
   localparam int IOT_DEV_MSB = 8;

   // Device select codes
   localparam logic [5:0] DEV_PTR = 6'o01;
   localparam logic [5:0] DEV_TTI = 6'o03;
   localparam logic [5:0] DEV_TTO = 6'o04;
   localparam logic [5:0] DEV_RF  = 6'o60;

   // Paper-tape reader fetch sequencer
   typedef enum logic [1:0] {
      PTR_IDLE = 2'd0,
      PTR_REQ  = 2'd1,
      PTR_WAIT = 2'd2
   } ptr_state_t;

endpackage

// File: rtl/pdp8_iot_decode.sv
// IOT select match and function-bit strobes for one pdp8_io device.
// Ports:
//   iot       in  current instruction is an IOT
//   state     in  CPU major state
//   fn        in  IOT function bits mb[2:0]
//   io_select in  device code from pdp8_io
//   strobe    out this device is addressed this clock
//   do_rpe    out strobe with fn==0 exactly (interrupt enable)
//   do_rsf    out strobe with fn[0] (skip on flag)
//   do_rrb    out strobe with fn[1] (read buffer)
//   do_rfc    out strobe with fn[2] (clear flag / fetch)
module pdp8_iot_decode
   import pdp8_ptr_pkg::*;
#(
   parameter logic [5:0] DEV_CODE = DEV_PTR
) (
   input  logic       iot,
   input  logic [3:0] state,
   input  logic [2:0] fn,
   input  logic [5:0] io_select,
   output logic       strobe,
   output logic       do_rpe,
   output logic       do_rsf,
   output logic       do_rrb,
   output logic       do_rfc
);

   // The device is addressed for exactly the one IOT-state clock of the instruction.
   // Function 0 is only meaningful on its own, the other bits combine freely.
   always_comb begin
      strobe = iot && (state == ST_IOT) && (io_select == DEV_CODE);
      do_rpe = strobe && (fn == 3'b000);
      do_rsf = strobe && fn[0];
      do_rrb = strobe && fn[1];
      do_rfc = strobe && fn[2];
   end

endmodule

// File: rtl/pdp8_ptr.sv
// PC8-style paper-tape reader on the pdp8_io device bus.
// RFC requests one frame from the tape source; after a mechanical step delay the
// frame is flagged ready, RSF skips on the flag and RRB ORs the frame into AC.
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   iot, state, mb          CPU instruction context
//   io_select               device code from pdp8_io
//   io_data_in              AC from CPU (not used by the reader)
//   io_data_out             {4'b0, buffer} during RRB, else 0
//   io_data_avail           io_data_out valid
//   io_clear_ac             always 0
//   io_skip                 skip request (RSF with flag set)
//   io_interrupt            flag & int_en
//   ptr_data, ptr_valid     frame from tape source
//   ptr_ready               reader requesting a frame
module pdp8_ptr
   import pdp8_ptr_pkg::*;
#(
   parameter logic [5:0] DEV_CODE   = DEV_PTR,
   parameter int         READ_DELAY = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iot,
   input  logic [3:0]  state,
   input  logic [11:0] mb,
   input  logic [5:0]  io_select,
   input  logic [11:0] io_data_in,
   output logic [11:0] io_data_out,
   output logic        io_data_avail,
   output logic        io_clear_ac,
   output logic        io_skip,
   output logic        io_interrupt,
   input  logic [7:0]  ptr_data,
   input  logic        ptr_valid,
   output logic        ptr_ready
);

   localparam int CW = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;

   ptr_state_t  fsm, fsm_next;
   logic [7:0]  buffer;
   logic        flag;
   logic        int_en;
   logic [CW-1:0] cnt;

   logic strobe, do_rpe, do_rsf, do_rrb, do_rfc;
   logic accept, flag_set, flag_clr, start_fetch;
   logic unused_bus;

   pdp8_iot_decode #(.DEV_CODE(DEV_CODE)) u_decode (
      .iot       (iot),
      .state     (state),
      .fn        (mb[IOT_FN_MSB:IOT_FN_LSB]),
      .io_select (io_select),
      .strobe    (strobe),
      .do_rpe    (do_rpe),
      .do_rsf    (do_rsf),
      .do_rrb    (do_rrb),
      .do_rfc    (do_rfc)
   );

   // Device select arrives separately on io_select, and the reader never reads AC.
   assign unused_bus = ^{io_data_in, mb[11:3]};

   // ptr_ready comes straight from the state register so it is glitch-free and
   // drops the moment reset is asserted.
   // RFC only starts a fetch from IDLE; a repeat while busy must not restart it.
   always_comb begin
      ptr_ready   = (fsm == PTR_REQ);
      accept      = ptr_ready && ptr_valid;
      start_fetch = do_rfc && (fsm == PTR_IDLE);
      flag_set    = (fsm == PTR_WAIT) && (cnt == '0);
      flag_clr    = do_rrb || do_rfc;
   end

   // Fetch sequencer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) fsm <= PTR_IDLE;
      else        fsm <= fsm_next;
   end

   // Fetch sequencer transitions: request a frame, then wait out the step time.
   always_comb begin
      fsm_next = fsm;
      case (fsm)
         PTR_IDLE: if (start_fetch) fsm_next = PTR_REQ;
         PTR_REQ:  if (accept)      fsm_next = PTR_WAIT;
         PTR_WAIT: if (cnt == '0)   fsm_next = PTR_IDLE;
         default:                   fsm_next = PTR_IDLE;
      endcase
   end

   // Frame buffer and step-delay counter. Loading READ_DELAY-1 at the accept edge
   // and setting the flag on the zero count puts the flag exactly READ_DELAY
   // clocks after the accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buffer <= '0;
         cnt    <= '0;
      end else begin
         if (start_fetch) buffer <= '0;
         else if (accept) buffer <= ptr_data;
         if (accept)                               cnt <= CW'(READ_DELAY - 1);
         else if (fsm == PTR_WAIT && cnt != '0)    cnt <= cnt - 1'b1;
      end
   end

   // Flag and interrupt enable. A CPU clear beats a same-clock set so software
   // never sees a frame it has already consumed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag   <= 1'b0;
         int_en <= 1'b1;
      end else begin
         if (flag_clr)      flag <= 1'b0;
         else if (flag_set) flag <= 1'b1;
         if (do_rpe) int_en <= 1'b1;
      end
   end

   // Bus outputs are zero outside the strobe clock so they can be ORed with other devices.
   always_comb begin
      io_skip       = do_rsf && flag;
      io_data_avail = do_rrb;
      io_data_out   = do_rrb ? {4'b0, buffer} : 12'o0000;
      io_clear_ac   = 1'b0;
      io_interrupt  = flag && int_en;
   end

endmodule

// File: tb/tb_pdp8_ptr.sv
module tb_pdp8_ptr;
   import pdp8_ptr_pkg::*;

   logic        clk;
   logic        reset;
   logic        iot;
   logic [3:0]  state;
   logic [11:0] mb;
   logic [5:0]  io_select;
   logic [11:0] io_data_in;
   logic [11:0] io_data_out;
   logic        io_data_avail;
   logic        io_clear_ac;
   logic        io_skip;
   logic        io_interrupt;
   logic [7:0]  ptr_data;
   logic        ptr_valid;
   logic        ptr_ready;

   int checks = 0;
   int passes = 0;
   logic [7:0] exp_q[$];

   pdp8_ptr #(.DEV_CODE(6'o01), .READ_DELAY(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .iot           (iot),
      .state         (state),
      .mb            (mb),
      .io_select     (io_select),
      .io_data_in    (io_data_in),
      .io_data_out   (io_data_out),
      .io_data_avail (io_data_avail),
      .io_clear_ac   (io_clear_ac),
      .io_skip       (io_skip),
      .io_interrupt  (io_interrupt),
      .ptr_data      (ptr_data),
      .ptr_valid     (ptr_valid),
      .ptr_ready     (ptr_ready)
   );

   // Free-running 10-unit clock; stimulus changes 1 unit after each rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive an IOT for the current cycle (caller sits 1 unit after a rising edge).
   task automatic iot_begin(input logic [11:0] word, input logic [5:0] sel);
      iot = 1'b1; state = ST_IOT; mb = word; io_select = sel;
   endtask

   task automatic iot_end();
      @(posedge clk); #1;
      iot = 1'b0; state = ST_FETCH; mb = 12'o0000; io_select = 6'o00;
   endtask

   // Tape source: wait for a request, hold off skip_clocks, then present one frame.
   task automatic feed_frame(input logic [7:0] d, input int skip_clocks);
      int n = 0;
      while (!ptr_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!ptr_ready) begin
         checks++;
         $display("[TB] FAIL feed_timeout: ptr_ready got %b want 1 within 50 clocks", ptr_ready);
      end
      repeat (skip_clocks) begin @(posedge clk); #1; end
      ptr_data = d; ptr_valid = 1'b1;
      exp_q.push_back(d);
      @(posedge clk); #1;
      ptr_valid = 1'b0; ptr_data = 8'h00;
   endtask

   task automatic fetch(input logic [7:0] d);
      iot_begin(12'o6014, DEV_PTR);
      iot_end();
      feed_frame(d, 0);
      repeat (16) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      reset = 1'b0; iot = 1'b0; state = ST_FETCH; mb = '0; io_select = '0;
      io_data_in = 12'o7777; ptr_data = '0; ptr_valid = 1'b0;
      #3;
      checks++;
      if ({ptr_ready, io_interrupt, io_skip, io_data_avail, io_clear_ac} !== 5'b0)
         $display("[TB] FAIL reset_ctl: got %b want 00000",
                  {ptr_ready, io_interrupt, io_skip, io_data_avail, io_clear_ac});
      else passes++;
      checks++;
      if (io_data_out !== 12'o0000) $display("[TB] FAIL reset_data: got %o want 0000", io_data_out);
      else passes++;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_empty_reads();
      iot_begin(12'o6011, DEV_PTR); #2;
      checks++;
      if (io_skip !== 1'b0) $display("[TB] FAIL rsf_noflag: skip got %b want 0", io_skip);
      else passes++;
      iot_end();
      iot_begin(12'o6012, DEV_PTR); #2;
      checks++;
      if ({io_data_avail, io_data_out} !== {1'b1, 12'o0000})
         $display("[TB] FAIL rrb_noflag: avail/data got %b/%o want 1/0000", io_data_avail, io_data_out);
      else passes++;
      iot_end();
   endtask

   task automatic test_fetch();
      logic [7:0] e;
      iot_begin(12'o6014, DEV_PTR);
      iot_end();
      checks++;
      if (ptr_ready !== 1'b1) $display("[TB] FAIL rfc_ready: got %b want 1", ptr_ready);
      else passes++;
      feed_frame(8'o215, 2);
      checks++;
      if (ptr_ready !== 1'b0) $display("[TB] FAIL ready_drop: got %b want 0", ptr_ready);
      else passes++;
      repeat (15) begin @(posedge clk); #1; end
      checks++;
      if (io_interrupt !== 1'b0) $display("[TB] FAIL flag_early: got %b want 0 at 15 clocks", io_interrupt);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (io_interrupt !== 1'b1) $display("[TB] FAIL flag_latency: got %b want 1 at 16 clocks", io_interrupt);
      else passes++;
      iot_begin(12'o6011, DEV_PTR); #2;
      checks++;
      if ({io_skip, io_data_avail} !== 2'b10)
         $display("[TB] FAIL rsf_flag: skip/avail got %b want 10", {io_skip, io_data_avail});
      else passes++;
      iot_end();
      iot_begin(12'o6012, DEV_PTR); #2;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if ({io_data_avail, io_clear_ac, io_data_out} !== {1'b1, 1'b0, 4'b0, e})
         $display("[TB] FAIL rrb_frame: avail/clr/data got %b/%b/%o want 1/0/%o",
                  io_data_avail, io_clear_ac, io_data_out, {4'b0, e});
      else passes++;
      iot_end();
      checks++;
      if (io_interrupt !== 1'b0) $display("[TB] FAIL rrb_clear: int got %b want 0", io_interrupt);
      else passes++;
   endtask

   task automatic test_rrb_rfc();
      logic [7:0] e;
      fetch(8'o377);
      iot_begin(12'o6016, DEV_PTR); #2;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if ({io_data_avail, io_skip, io_data_out} !== {1'b1, 1'b0, 4'b0, e})
         $display("[TB] FAIL op6016_data: avail/skip/data got %b/%b/%o want 1/0/%o",
                  io_data_avail, io_skip, io_data_out, {4'b0, e});
      else passes++;
      iot_end();
      checks++;
      if ({ptr_ready, io_interrupt} !== 2'b10)
         $display("[TB] FAIL op6016_fetch: ready/int got %b want 10", {ptr_ready, io_interrupt});
      else passes++;
      iot_begin(12'o6012, DEV_PTR); #2;
      checks++;
      if (io_data_out !== 12'o0000) $display("[TB] FAIL op6016_bufclr: got %o want 0000", io_data_out);
      else passes++;
      iot_end();
      feed_frame(8'o042, 0);
      repeat (16) begin @(posedge clk); #1; end
      iot_begin(12'o6012, DEV_PTR); #2;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (io_data_out !== {4'b0, e}) $display("[TB] FAIL op6016_next: got %o want %o", io_data_out, {4'b0, e});
      else passes++;
      iot_end();
   endtask

   task automatic test_rfc_during_wait();
      logic ready_seen = 1'b0;
      logic early_int = 1'b0;
      logic [7:0] e;
      iot_begin(12'o6014, DEV_PTR);
      iot_end();
      feed_frame(8'o123, 0);
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         ready_seen |= ptr_ready;
         if (k < 16) early_int |= io_interrupt;
         iot = (k == 3 || k == 7 || k == 11); state = ST_IOT; mb = 12'o6014; io_select = DEV_PTR;
      end
      iot = 1'b0; state = ST_FETCH;
      checks++;
      if ({ready_seen, early_int, io_interrupt} !== 3'b001)
         $display("[TB] FAIL rfc_wait: ready_seen/early/int got %b want 001",
                  {ready_seen, early_int, io_interrupt});
      else passes++;
      ready_seen = 1'b0;
      repeat (5) begin @(posedge clk); #1; ready_seen |= ptr_ready; end
      checks++;
      if (ready_seen !== 1'b0) $display("[TB] FAIL rfc_wait_idle: ready got %b want 0", ready_seen);
      else passes++;
      iot_begin(12'o6012, DEV_PTR); #2;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (io_data_out !== {4'b0, e}) $display("[TB] FAIL rfc_wait_frame: got %o want %o", io_data_out, {4'b0, e});
      else passes++;
      iot_end();
   endtask

   task automatic test_set_clear_collision();
      logic [7:0] e;
      iot_begin(12'o6014, DEV_PTR);
      iot_end();
      feed_frame(8'o055, 0);
      repeat (15) begin @(posedge clk); #1; end
      iot_begin(12'o6012, DEV_PTR); #2;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (io_data_out !== {4'b0, e}) $display("[TB] FAIL collide_data: got %o want %o", io_data_out, {4'b0, e});
      else passes++;
      iot_end();
      checks++;
      if (io_interrupt !== 1'b0) $display("[TB] FAIL collide_flag: int got %b want 0", io_interrupt);
      else passes++;
   endtask

   task automatic test_interrupt_select();
      logic [7:0] e;
      fetch(8'o125);
      checks++;
      if (io_interrupt !== 1'b1) $display("[TB] FAIL int_level: got %b want 1", io_interrupt);
      else passes++;
      iot_begin(12'o6012, 6'o03); #2;
      checks++;
      if ({io_data_avail, io_skip, io_data_out} !== {2'b00, 12'o0000})
         $display("[TB] FAIL wrong_sel: avail/skip/data got %b/%b/%o want 0/0/0000",
                  io_data_avail, io_skip, io_data_out);
      else passes++;
      iot_end();
      checks++;
      if (io_interrupt !== 1'b1) $display("[TB] FAIL int_held: got %b want 1", io_interrupt);
      else passes++;
      iot_begin(12'o6012, DEV_PTR); #2;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (io_data_out !== {4'b0, e}) $display("[TB] FAIL int_read: got %o want %o", io_data_out, {4'b0, e});
      else passes++;
      iot_end();
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      fetch(8'o314);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({io_interrupt, ptr_ready} !== 2'b00)
         $display("[TB] FAIL rst_flag: int/ready got %b want 00", {io_interrupt, ptr_ready});
      else passes++;
      exp_q.delete();
      @(posedge clk); #1 reset = 1'b1;
      iot_begin(12'o6014, DEV_PTR);
      iot_end();
      @(posedge clk); #1;
      #2 reset = 1'b0; ptr_data = 8'o377; ptr_valid = 1'b1;
      #1;
      checks++;
      if (ptr_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", ptr_ready);
      else passes++;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 ptr_valid = 1'b0;
      checks++;
      if (ptr_ready !== 1'b0) $display("[TB] FAIL rst_idle: got %b want 0", ptr_ready);
      else passes++;
      iot_begin(12'o6012, DEV_PTR); #2;
      checks++;
      if (io_data_out !== 12'o0000) $display("[TB] FAIL rst_discard: got %o want 0000", io_data_out);
      else passes++;
      iot_end();
      fetch(8'o001);
      checks++;
      if (io_interrupt !== 1'b1) $display("[TB] FAIL rst_int_en: got %b want 1", io_interrupt);
      else passes++;
      iot_begin(12'o6012, DEV_PTR); #2;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (io_data_out !== {4'b0, e}) $display("[TB] FAIL rst_refetch: got %o want %o", io_data_out, {4'b0, e});
      else passes++;
      iot_end();
   endtask

   initial begin
      test_reset();
      test_empty_reads();
      test_fetch();
      test_rrb_rfc();
      test_rfc_during_wait();
      test_set_clear_collision();
      test_interrupt_select();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
